// File: rtl/punc_mc_control_if.sv
// Datapath-side bus of the PUnC multi-cycle controller: instruction/condition
// inputs from the datapath and every select/strobe that drives it.
interface punc_mc_control_if;
  logic [15:0] ir;
  logic        n, z, p;
  logic        mem_w_en;
  logic [1:0]  mem_r_addr_sel;
  logic [1:0]  mem_w_addr_sel;
  logic        mem_w_data_sel;
  logic        rf_w_en;
  logic        rf_w_addr_sel;
  logic [1:0]  rf_w_data_sel;
  logic        rf_r0_addr_sel;
  logic        rf_r1_addr_sel;
  logic        ir_ld, pc_ld, pc_clr, pc_inc;
  logic [1:0]  pc_ld_data_sel;
  logic [2:0]  alu_sel;
  logic        cond_ld, cond_ld_data_sel;
  logic        ind_reg_ld;

  modport master (
    input  ir, n, z, p,
    output mem_w_en, mem_r_addr_sel, mem_w_addr_sel, mem_w_data_sel,
           rf_w_en, rf_w_addr_sel, rf_w_data_sel, rf_r0_addr_sel, rf_r1_addr_sel,
           ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel, alu_sel,
           cond_ld, cond_ld_data_sel, ind_reg_ld
  );

  modport slave (
    output ir, n, z, p,
    input  mem_w_en, mem_r_addr_sel, mem_w_addr_sel, mem_w_data_sel,
           rf_w_en, rf_w_addr_sel, rf_w_data_sel, rf_r0_addr_sel, rf_r1_addr_sel,
           ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel, alu_sel,
           cond_ld, cond_ld_data_sel, ind_reg_ld
  );
endinterface

// File: rtl/punc_mc_control.sv
// PUnC LC3 multi-cycle controller: fetch/decode/execute sequencing with
// configurable memory read latency, LDI/STI indirection and retire counting.
module punc_mc_control #(
  parameter int unsigned MEM_LAT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  punc_mc_control_if.master      dp,
  output logic                   halted,
  output logic                   illegal,
  output logic [CNT_W-1:0]       retired
);

  typedef enum logic [2:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_IND, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_BR  = 4'd0,  OP_ADD = 4'd1,  OP_LD  = 4'd2,  OP_ST   = 4'd3,
    OP_JSR = 4'd4,  OP_AND = 4'd5,  OP_LDR = 4'd6,  OP_STR  = 4'd7,
    OP_RTI = 4'd8,  OP_NOT = 4'd9,  OP_LDI = 4'd10, OP_STI  = 4'd11,
    OP_JMP = 4'd12, OP_RES = 4'd13, OP_LEA = 4'd14, OP_TRAP = 4'd15
  } op_t;

  state_t     state, state_nx;
  op_t        op;
  logic [3:0] wcnt;
  logic       last;
  logic       ret_inc, set_illegal;

  assign op   = op_t'(dp.ir[15:12]);
  assign last = (wcnt == 4'(MEM_LAT));

  // Wait counter restarts on every state change and saturates at MEM_LAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_INIT;
      wcnt    <= '0;
      retired <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) wcnt <= '0;
      else if (!last)        wcnt <= wcnt + 4'd1;
      if (ret_inc)              retired <= retired + CNT_W'(1);
      if (state_nx == S_HALT)   halted  <= 1'b1;
      if (set_illegal)          illegal <= 1'b1;
    end
  end

  always_comb begin
    state_nx            = state;
    ret_inc             = 1'b0;
    set_illegal         = 1'b0;
    dp.mem_w_en         = 1'b0;
    dp.mem_r_addr_sel   = 2'd0;
    dp.mem_w_addr_sel   = 2'd0;
    dp.mem_w_data_sel   = 1'b0;
    dp.rf_w_en          = 1'b0;
    dp.rf_w_addr_sel    = 1'b0;
    dp.rf_w_data_sel    = 2'd0;
    dp.rf_r0_addr_sel   = 1'b0;
    dp.rf_r1_addr_sel   = 1'b0;
    dp.ir_ld            = 1'b0;
    dp.pc_ld            = 1'b0;
    dp.pc_clr           = 1'b0;
    dp.pc_inc           = 1'b0;
    dp.pc_ld_data_sel   = 2'd0;
    dp.alu_sel          = 3'd0;
    dp.cond_ld          = 1'b0;
    dp.cond_ld_data_sel = 1'b0;
    dp.ind_reg_ld       = 1'b0;
    // Strobes are held off for the whole reset cycle regardless of state.
    if (!rst) begin
      case (state)
        S_INIT: begin
          dp.pc_clr = 1'b1;
          state_nx  = S_FETCH;
        end
        S_FETCH: begin
          if (last) begin
            dp.ir_ld = 1'b1;
            state_nx = S_DECODE;
          end
        end
        S_DECODE: begin
          dp.pc_inc = 1'b1;
          state_nx  = S_EXEC;
        end
        S_EXEC: begin
          state_nx = S_FETCH;
          case (op)
            OP_ADD, OP_AND: begin
              dp.rf_w_en  = 1'b1;
              dp.cond_ld  = 1'b1;
              dp.alu_sel  = {1'b0, op == OP_AND, dp.ir[5]};
            end
            OP_NOT: begin
              dp.rf_w_en = 1'b1;
              dp.cond_ld = 1'b1;
              dp.alu_sel = 3'd4;
            end
            OP_BR: begin
              dp.pc_ld = (dp.n & dp.ir[11]) | (dp.z & dp.ir[10]) | (dp.p & dp.ir[9]);
            end
            OP_JMP: begin
              dp.pc_ld          = 1'b1;
              dp.pc_ld_data_sel = 2'd1;
            end
            OP_JSR: begin
              dp.rf_w_en        = 1'b1;
              dp.rf_w_addr_sel  = 1'b1;
              dp.rf_w_data_sel  = 2'd2;
              dp.pc_ld          = 1'b1;
              dp.pc_ld_data_sel = dp.ir[11] ? 2'd2 : 2'd1;
            end
            OP_LD, OP_LDR: begin
              dp.mem_r_addr_sel   = (op == OP_LD) ? 2'd1 : 2'd2;
              dp.rf_w_data_sel    = 2'd1;
              dp.cond_ld_data_sel = 1'b1;
              if (last) begin
                dp.rf_w_en = 1'b1;
                dp.cond_ld = 1'b1;
              end else begin
                state_nx = S_EXEC;
              end
            end
            OP_LEA: begin
              dp.rf_w_en          = 1'b1;
              dp.rf_w_data_sel    = 2'd3;
              dp.cond_ld          = 1'b1;
              dp.cond_ld_data_sel = 1'b1;
            end
            OP_ST, OP_STR: begin
              dp.mem_w_en       = 1'b1;
              dp.mem_w_addr_sel = (op == OP_ST) ? 2'd1 : 2'd2;
              dp.rf_r0_addr_sel = 1'b1;
              dp.rf_r1_addr_sel = (op == OP_STR);
            end
            OP_LDI, OP_STI: begin
              dp.mem_r_addr_sel = 2'd1;
              if (last) begin
                dp.ind_reg_ld = 1'b1;
                state_nx      = S_IND;
              end else begin
                state_nx = S_EXEC;
              end
            end
            OP_TRAP: begin
              state_nx = S_HALT;
              ret_inc  = 1'b1;
            end
            OP_RTI, OP_RES: begin
              state_nx    = S_HALT;
              set_illegal = 1'b1;
            end
          endcase
          if (state_nx == S_FETCH) ret_inc = 1'b1;
        end
        S_IND: begin
          if (op == OP_LDI) begin
            dp.mem_r_addr_sel   = 2'd3;
            dp.rf_w_data_sel    = 2'd1;
            dp.cond_ld_data_sel = 1'b1;
            if (last) begin
              dp.rf_w_en = 1'b1;
              dp.cond_ld = 1'b1;
              state_nx   = S_FETCH;
              ret_inc    = 1'b1;
            end
          end else begin
            dp.mem_w_en       = 1'b1;
            dp.mem_w_addr_sel = 2'd3;
            dp.rf_r0_addr_sel = 1'b1;
            state_nx          = S_FETCH;
            ret_inc           = 1'b1;
          end
        end
        S_HALT: ;
        default: state_nx = S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_mc_control.sv
// Bench for punc_mc_control: table of instructions on a MEM_LAT=2 core with a
// retire scoreboard, plus a MEM_LAT=0 / CNT_W=2 core for cycle timing and wrap.
module tb_punc_mc_control;
  localparam int LA = 2;

  typedef struct packed {
    logic       mem_w_en;
    logic [1:0] mem_r_addr_sel;
    logic [1:0] mem_w_addr_sel;
    logic       mem_w_data_sel;
    logic       rf_w_en;
    logic       rf_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_r0_addr_sel;
    logic       rf_r1_addr_sel;
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_ld_data_sel;
    logic [2:0] alu_sel;
    logic       cond_ld;
    logic       cond_ld_data_sel;
    logic       ind_reg_ld;
  } ctrl_t;

  typedef struct {
    logic [15:0] ir;
    logic        n, z, p;
    ctrl_t       last;
    int          cycles;
    int          rfw, ind, memw;
  } row_t;

  typedef struct {
    row_t        r;
    logic [15:0] exp_ret;
  } sb_t;

  logic clk = 0;
  logic rst_a = 1, rst_b = 1;
  logic halted_a, illegal_a, halted_b, illegal_b;
  logic [15:0] retired_a;
  logic [1:0]  retired_b;

  punc_mc_control_if ifa ();
  punc_mc_control_if ifb ();

  punc_mc_control #(.MEM_LAT(LA), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .dp(ifa),
    .halted(halted_a), .illegal(illegal_a), .retired(retired_a)
  );

  punc_mc_control #(.MEM_LAT(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .dp(ifb),
    .halted(halted_b), .illegal(illegal_b), .retired(retired_b)
  );

  always #5 clk = ~clk;

  int    total = 0, bad = 0;
  row_t  rows[$];
  sb_t   sb[$];
  ctrl_t hist[0:63];
  int    ret_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic ctrl_t snap_a();
    ctrl_t c;
    c.mem_w_en         = ifa.mem_w_en;
    c.mem_r_addr_sel   = ifa.mem_r_addr_sel;
    c.mem_w_addr_sel   = ifa.mem_w_addr_sel;
    c.mem_w_data_sel   = ifa.mem_w_data_sel;
    c.rf_w_en          = ifa.rf_w_en;
    c.rf_w_addr_sel    = ifa.rf_w_addr_sel;
    c.rf_w_data_sel    = ifa.rf_w_data_sel;
    c.rf_r0_addr_sel   = ifa.rf_r0_addr_sel;
    c.rf_r1_addr_sel   = ifa.rf_r1_addr_sel;
    c.ir_ld            = ifa.ir_ld;
    c.pc_ld            = ifa.pc_ld;
    c.pc_clr           = ifa.pc_clr;
    c.pc_inc           = ifa.pc_inc;
    c.pc_ld_data_sel   = ifa.pc_ld_data_sel;
    c.alu_sel          = ifa.alu_sel;
    c.cond_ld          = ifa.cond_ld;
    c.cond_ld_data_sel = ifa.cond_ld_data_sel;
    c.ind_reg_ld       = ifa.ind_reg_ld;
    return c;
  endfunction

  task automatic add_row(input logic [15:0] ir, input logic n, input logic z, input logic p,
                         input ctrl_t last, input int cycles, input int rfw, input int ind,
                         input int memw);
    row_t r;
    r.ir = ir; r.n = n; r.z = z; r.p = p; r.last = last;
    r.cycles = cycles; r.rfw = rfw; r.ind = ind; r.memw = memw;
    rows.push_back(r);
  endtask

  task automatic wait_irld(input string tag);
    int k = 0;
    do begin @(negedge clk); k++; end while (!ifa.ir_ld && k < 50);
    chk({tag, " ir_ld"}, 32'(ifa.ir_ld), 1);
  endtask

  // Raise rst for one clock, then release and expect INIT with pc_clr.
  task automatic do_reset_a(input string tag);
    ctrl_t e;
    @(posedge clk); #1 rst_a = 1;
    @(negedge clk);
    chk({tag, " rst-cycle strobes"}, 32'(snap_a()), 0);
    @(posedge clk); #1 rst_a = 0;
    @(negedge clk);
    e = '0; e.pc_clr = 1'b1;
    chk({tag, " init vec"}, 32'(snap_a()), 32'(e));
    chk({tag, " retired"}, 32'(retired_a), 0);
    chk({tag, " halted"}, 32'(halted_a), 0);
    chk({tag, " illegal"}, 32'(illegal_a), 0);
    ret_model = 0;
  endtask

  task automatic halt_run(input logic [15:0] ir, input string tag, input logic exp_ill);
    int k = 0, noisy = 0;
    @(posedge clk); #1 ifa.ir = ir;
    do begin @(negedge clk); k++; end while (!halted_a && k < 20);
    chk({tag, " halt latency"}, 32'(k), 3);
    chk({tag, " illegal"}, 32'(illegal_a), 32'(exp_ill));
    chk({tag, " retired"}, 32'(retired_a), 32'(ret_model));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (snap_a() != '0 || !halted_a || illegal_a !== exp_ill) noisy++;
    end
    chk({tag, " quiet halt cycles"}, 32'(noisy), 0);
  endtask

  initial begin
    ctrl_t c;
    logic [1:0] wrap_seq [0:4];
    ifa.ir = '0; ifa.n = 0; ifa.z = 0; ifa.p = 0;
    ifb.ir = 16'h1263; ifb.n = 0; ifb.z = 0; ifb.p = 0;

    c = '0; c.rf_w_en = 1; c.cond_ld = 1;
    add_row(16'h1283, 0, 0, 0, c, LA + 3, 1, 0, 0);          // ADD reg
    c.alu_sel = 3'd1; add_row(16'h1263, 0, 0, 0, c, LA + 3, 1, 0, 0);
    c.alu_sel = 3'd2; add_row(16'h54C4, 0, 0, 0, c, LA + 3, 1, 0, 0);
    c.alu_sel = 3'd3; add_row(16'h54FF, 0, 0, 0, c, LA + 3, 1, 0, 0);
    c.alu_sel = 3'd4; add_row(16'h92BF, 0, 0, 0, c, LA + 3, 1, 0, 0); // NOT
    c = '0; c.pc_ld = 1;
    add_row(16'h0405, 0, 1, 0, c, LA + 3, 0, 0, 0);          // BRz, z=1
    add_row(16'h0A05, 0, 0, 1, c, LA + 3, 0, 0, 0);          // BRnp, p=1
    c = '0;
    add_row(16'h0405, 1, 0, 0, c, LA + 3, 0, 0, 0);          // BRz, z=0
    add_row(16'h0005, 1, 1, 1, c, LA + 3, 0, 0, 0);          // BR 000
    c = '0; c.pc_ld = 1; c.pc_ld_data_sel = 2'd1;
    add_row(16'hC0C0, 0, 0, 0, c, LA + 3, 0, 0, 0);          // JMP R3
    c.rf_w_en = 1; c.rf_w_addr_sel = 1; c.rf_w_data_sel = 2'd2;
    add_row(16'h41C0, 0, 0, 0, c, LA + 3, 1, 0, 0);          // JSRR R7
    c.pc_ld_data_sel = 2'd2;
    add_row(16'h4803, 0, 0, 0, c, LA + 3, 1, 0, 0);          // JSR
    c = '0; c.rf_w_en = 1; c.rf_w_data_sel = 2'd3; c.cond_ld = 1; c.cond_ld_data_sel = 1;
    add_row(16'hE805, 0, 0, 0, c, LA + 3, 1, 0, 0);          // LEA
    c = '0; c.mem_w_en = 1; c.mem_w_addr_sel = 2'd1; c.rf_r0_addr_sel = 1;
    add_row(16'h3A05, 0, 0, 0, c, LA + 3, 0, 0, 1);          // ST
    c.mem_w_addr_sel = 2'd2; c.rf_r1_addr_sel = 1;
    add_row(16'h7B81, 0, 0, 0, c, LA + 3, 0, 0, 1);          // STR
    c = '0; c.mem_r_addr_sel = 2'd1; c.rf_w_en = 1; c.rf_w_data_sel = 2'd1;
    c.cond_ld = 1; c.cond_ld_data_sel = 1;
    add_row(16'h2405, 0, 0, 0, c, 2*LA + 3, 1, 0, 0);        // LD
    c.mem_r_addr_sel = 2'd2;
    add_row(16'h64C1, 0, 0, 0, c, 2*LA + 3, 1, 0, 0);        // LDR
    c.mem_r_addr_sel = 2'd3;
    add_row(16'hA405, 0, 0, 0, c, 3*LA + 4, 1, 1, 0);        // LDI
    c = '0; c.mem_w_en = 1; c.mem_w_addr_sel = 2'd3; c.rf_r0_addr_sel = 1;
    add_row(16'hBA05, 0, 0, 0, c, 2*LA + 4, 0, 1, 1);        // STI
    wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
    wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;

    do_reset_a("por");
    wait_irld("first fetch");

    foreach (rows[i]) begin
      sb_t e;
      int k, rfw, ind, memw;
      ctrl_t d, f;
      @(posedge clk); #1;
      ifa.ir = rows[i].ir; ifa.n = rows[i].n; ifa.z = rows[i].z; ifa.p = rows[i].p;
      ret_model++;
      e.r = rows[i]; e.exp_ret = 16'(ret_model);
      sb.push_back(e);
      k = 0;
      do begin
        @(negedge clk); k++;
        hist[k] = snap_a();
      end while (!hist[k].ir_ld && k < 60);
      e = sb.pop_front();
      chk($sformatf("row%0d %h cycles", i, e.r.ir), 32'(k), 32'(e.r.cycles));
      if (k > LA + 1 && k < 60) begin
        rfw = 0; ind = 0; memw = 0;
        for (int j = 1; j < k; j++) begin
          rfw  += int'(hist[j].rf_w_en);
          ind  += int'(hist[j].ind_reg_ld);
          memw += int'(hist[j].mem_w_en);
        end
        d = '0; d.pc_inc = 1;
        f = '0; f.ir_ld = 1;
        chk($sformatf("row%0d decode vec", i), 32'(hist[1]), 32'(d));
        chk($sformatf("row%0d last vec", i), 32'(hist[k-LA-1]), 32'(e.r.last));
        chk($sformatf("row%0d next fetch vec", i), 32'(hist[k]), 32'(f));
        chk($sformatf("row%0d rf_w_en pulses", i), 32'(rfw), 32'(e.r.rfw));
        chk($sformatf("row%0d ind_reg_ld pulses", i), 32'(ind), 32'(e.r.ind));
        chk($sformatf("row%0d mem_w_en pulses", i), 32'(memw), 32'(e.r.memw));
      end
      chk($sformatf("row%0d retired", i), 32'(retired_a), 32'(e.exp_ret));
    end

    // LDI interrupted by rst during its indirect read wait.
    @(posedge clk); #1 ifa.ir = 16'hA405;
    repeat (LA + 3) @(negedge clk);
    chk("ldi ind rsel", 32'(ifa.mem_r_addr_sel), 3);
    chk("ldi pre-rst retired", 32'(retired_a), 32'(ret_model));
    do_reset_a("mid-ind");

    wait_irld("illegal fetch");
    halt_run(16'hD000, "op1101", 1'b1);

    do_reset_a("after illegal");
    wait_irld("trap fetch");
    ret_model++;
    halt_run(16'hF025, "op1111", 1'b0);

    // Second core: MEM_LAT=0 cycle timing and 2-bit retire wrap.
    @(posedge clk); #1 rst_b = 0;
    @(negedge clk);
    chk("b pc_clr", 32'(ifb.pc_clr), 1);
    chk("b retired at init", 32'(retired_b), 0);
    @(negedge clk);
    chk("b first ir_ld", 32'(ifb.ir_ld), 1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("b%0d pc_inc", j), 32'(ifb.pc_inc), 1);
      @(negedge clk);
      chk($sformatf("b%0d exec", j),
          {28'd0, ifb.rf_w_en, ifb.alu_sel}, {28'd0, 1'b1, 3'd1});
      chk($sformatf("b%0d cond_ld", j), 32'(ifb.cond_ld), 1);
      @(negedge clk);
      chk($sformatf("b%0d ir_ld", j), 32'(ifb.ir_ld), 1);
      chk($sformatf("b%0d retired", j), 32'(retired_b), 32'(wrap_seq[j]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
